// File: rtl/uart_apb_regs_fifo.sv
// APB register front-end for the UART core: TX/RX FIFOs, baud/frame config, W1C interrupt status.
// Optional TX->RX loopback path is compiled in when UART_LOOPBACK_EN is defined.

module uart_apb_regs_fifo_buf #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                        pClk,
   input  logic                        pReset,
   input  logic                        pushReq,
   input  logic [DATA_W-1:0]           pushData,
   input  logic                        popReq,
   input  logic                        flush,
   output logic [DATA_W-1:0]           head,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(DEPTH):0]      level,
   output logic [$clog2(DEPTH):0]      levelNext,
   output logic                        pushDrop,
   output logic                        popAck
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wrPtr;
   logic [AW-1:0]     rdPtr;
   logic [LW-1:0]     count;
   logic              pushAck;

   assign empty    = (count == '0);
   assign full     = (count == LW'(DEPTH));
   assign head     = mem[rdPtr];
   assign level    = count;
   // A pop on empty is ignored; a push on full survives only alongside a real pop.
   assign popAck   = popReq & ~empty;
   assign pushAck  = pushReq & ~flush & (~full | popAck);
   assign pushDrop = pushReq & ~flush & full & ~popAck;

   always_comb begin
      levelNext = count;
      if (flush)
         levelNext = '0;
      else if (pushAck & ~popAck)
         levelNext = count + LW'(1);
      else if (~pushAck & popAck)
         levelNext = count - LW'(1);
   end

   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         count <= levelNext;
         if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
         end else begin
            if (pushAck) wrPtr <= wrPtr + AW'(1);
            if (popAck)  rdPtr <= rdPtr + AW'(1);
         end
      end
   end

   always_ff @(posedge pClk) begin
      if (pushAck) mem[wrPtr] <= pushData;
   end
endmodule

module uart_apb_regs_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned TX_DEPTH = 16,
   parameter int unsigned RX_DEPTH = 16,
   parameter logic [15:0] BAUD_RST = 16'd325
) (
   input  logic              pClk,
   input  logic              pReset,
   input  logic              pSel,
   input  logic              pEnable,
   input  logic              pWrite,
   input  logic [7:0]        pAddr,
   input  logic [31:0]       pWdata,
   output logic [31:0]       pRdata,
   output logic              pReady,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_frame_err,
   input  logic              rx_parity_err,
   output logic [15:0]       baud_div,
   output logic [4:0]        cfg,
   output logic              rx_en,
   output logic              irq
);
   localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
   localparam int unsigned RX_LW = $clog2(RX_DEPTH) + 1;

   localparam logic [5:0] ADDR_DATA    = 6'h00;
   localparam logic [5:0] ADDR_CTRL    = 6'h01;
   localparam logic [5:0] ADDR_BAUD    = 6'h02;
   localparam logic [5:0] ADDR_CFG     = 6'h03;
   localparam logic [5:0] ADDR_STATUS  = 6'h04;
   localparam logic [5:0] ADDR_INTEN   = 6'h05;
   localparam logic [5:0] ADDR_INTSTAT = 6'h06;
   localparam logic [5:0] ADDR_RXTHR   = 6'h07;

   logic              wrAcc, rdAcc;
   logic [5:0]        addrWord;
   logic              wrData, wrCtrl, wrBaud, wrCfg, wrIntEn, wrIntStat, wrRxThr, rdData;
   logic              txEn, rxEn, lpbkBit;
   logic [15:0]       baudReg;
   logic [4:0]        cfgReg;
   logic [5:0]        intEn;
   logic [5:1]        intStat, intStatNext, setBits, clrBits;
   logic [7:0]        rxThr, effThr;
   logic              rxThrNow, rxThrNext;
   logic [31:0]       rdMux;

   logic              txFlush, txPopReq, txEmpty, txFull, txPushDrop, txPopAck, txDone;
   logic [DATA_W-1:0] txHead;
   logic [TX_LW-1:0]  txLevel, txLevelNext;
   logic              rxFlush, rxPushReq, rxPopReq, rxEmpty, rxFull, rxPushDrop, rxPopAck, rxLine;
   logic [DATA_W-1:0] rxHead, rxPushData;
   logic [RX_LW-1:0]  rxLevel, rxLevelNext;
   logic              unusedBits;

   // APB decode; pAddr[1:0] are ignored
   assign wrAcc     = pSel & pEnable & pWrite;
   assign rdAcc     = pSel & pEnable & ~pWrite;
   assign addrWord  = pAddr[7:2];
   assign wrData    = wrAcc & (addrWord == ADDR_DATA);
   assign wrCtrl    = wrAcc & (addrWord == ADDR_CTRL);
   assign wrBaud    = wrAcc & (addrWord == ADDR_BAUD);
   assign wrCfg     = wrAcc & (addrWord == ADDR_CFG);
   assign wrIntEn   = wrAcc & (addrWord == ADDR_INTEN);
   assign wrIntStat = wrAcc & (addrWord == ADDR_INTSTAT);
   assign wrRxThr   = wrAcc & (addrWord == ADDR_RXTHR);
   assign rdData    = rdAcc & (addrWord == ADDR_DATA);

   assign txFlush   = wrCtrl & pWdata[3];
   assign rxFlush   = wrCtrl & pWdata[4];
   assign rxPopReq  = rdData;

`ifdef UART_LOOPBACK_EN
   logic lpbk, lbMove;

   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset)      lpbk <= 1'b0;
      else if (wrCtrl) lpbk <= pWdata[2];
   end

   // Loopback moves only when RX has room, so it can never overrun
   assign lbMove     = lpbk & txEn & ~txEmpty & ~rxFull;
   assign lpbkBit    = lpbk;
   assign tx_valid   = txEn & ~txEmpty & ~lpbk;
   assign rxLine     = rx_valid & rxEn & ~lpbk;
   assign txPopReq   = (tx_valid & tx_ready) | lbMove;
   assign rxPushReq  = rxLine | lbMove;
   assign rxPushData = lbMove ? txHead : rx_data;
`else
   assign lpbkBit    = 1'b0;
   assign tx_valid   = txEn & ~txEmpty;
   assign rxLine     = rx_valid & rxEn;
   assign txPopReq   = tx_valid & tx_ready;
   assign rxPushReq  = rxLine;
   assign rxPushData = rx_data;
`endif

   uart_apb_regs_fifo_buf #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) uTxFifo (
      .pClk      (pClk),
      .pReset    (pReset),
      .pushReq   (wrData),
      .pushData  (pWdata[DATA_W-1:0]),
      .popReq    (txPopReq),
      .flush     (txFlush),
      .head      (txHead),
      .empty     (txEmpty),
      .full      (txFull),
      .level     (txLevel),
      .levelNext (txLevelNext),
      .pushDrop  (txPushDrop),
      .popAck    (txPopAck)
   );

   uart_apb_regs_fifo_buf #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) uRxFifo (
      .pClk      (pClk),
      .pReset    (pReset),
      .pushReq   (rxPushReq),
      .pushData  (rxPushData),
      .popReq    (rxPopReq),
      .flush     (rxFlush),
      .head      (rxHead),
      .empty     (rxEmpty),
      .full      (rxFull),
      .level     (rxLevel),
      .levelNext (rxLevelNext),
      .pushDrop  (rxPushDrop),
      .popAck    (rxPopAck)
   );

   assign tx_data  = txHead;
   assign pReady   = 1'b1;
   assign baud_div = baudReg;
   assign cfg      = cfgReg;
   assign rx_en    = rxEn;

   // Interrupt sources; a set in the same cycle as a W1C clear wins
   assign txDone      = txPopAck & (txLevel == TX_LW'(1)) & (txLevelNext == '0);
   assign setBits     = {txPushDrop, rxLine & rx_parity_err, rxLine & rx_frame_err, rxPushDrop, txDone};
   assign clrBits     = wrIntStat ? pWdata[5:1] : 5'b0;
   assign intStatNext = (intStat & ~clrBits) | setBits;
   assign effThr      = (rxThr == 8'd0) ? 8'd1 : rxThr;
   assign rxThrNow    = 32'(rxLevel) >= 32'(effThr);
   assign rxThrNext   = 32'(rxLevelNext) >= 32'(effThr);

   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset) begin
         txEn    <= 1'b0;
         rxEn    <= 1'b0;
         baudReg <= BAUD_RST;
         cfgReg  <= 5'd0;
         intEn   <= 6'd0;
         intStat <= 5'd0;
         rxThr   <= 8'd1;
         irq     <= 1'b0;
      end else begin
         if (wrCtrl) begin
            txEn <= pWdata[0];
            rxEn <= pWdata[1];
         end
         if (wrBaud)  baudReg <= pWdata[15:0];
         if (wrCfg)   cfgReg  <= pWdata[4:0];
         if (wrIntEn) intEn   <= pWdata[5:0];
         if (wrRxThr) rxThr   <= pWdata[7:0];
         intStat <= intStatNext;
         irq     <= |({intStatNext, rxThrNext} & intEn);
      end
   end

   always_comb begin
      rdMux = 32'd0;
      if (rdAcc) begin
         case (addrWord)
            ADDR_DATA:    rdMux = rxEmpty ? 32'd0 : 32'(rxHead);
            ADDR_CTRL:    rdMux = 32'({lpbkBit, rxEn, txEn});
            ADDR_BAUD:    rdMux = 32'(baudReg);
            ADDR_CFG:     rdMux = 32'(cfgReg);
            ADDR_STATUS:  rdMux = {8'h00, 8'(rxLevel), 8'(txLevel), 4'h0, rxFull, rxEmpty, txFull, txEmpty};
            ADDR_INTEN:   rdMux = 32'(intEn);
            ADDR_INTSTAT: rdMux = 32'({intStat, rxThrNow});
            ADDR_RXTHR:   rdMux = 32'(rxThr);
            default:      rdMux = 32'd0;
         endcase
      end
   end

   assign pRdata = rdMux;

   assign unusedBits = ^{pAddr[1:0], pWdata[31:16], rxPopAck};
endmodule
